rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port among N_REQ writeback requesters (ALU, LSU).
//  - Per-requester one-entry hold register; round-robin grant; registered write-port drive.
//  - Scoreboard of pending writes per architectural register gives the issue stage a
//    RAW/WAW stall signal. Sits between the EX/MEM writeback paths and the RF write port.
// PARAMETERS
//  N_REQ   2  number of writeback requesters (>=2); index 0 = ALU, 1 = LSU
//  PEND_W  2  width of per-register pending-write counter (max 2**PEND_W-1 in flight)
// PORTS
//  clock      in   1             rising-edge clock
//  reset_n    in   1             asynchronous active-low reset
//  req_valid  in   [N_REQ]       requester i offers a write
//  req_dst    in   t_RFadrs[N_REQ]  destination register of offer i
//  req_data   in   t_data[N_REQ]    data of offer i
//  req_ready  out  [N_REQ]       hold register i accepts this cycle
//  rsv_valid  in   1             issue stage reserves a destination
//  rsv_dst    in   t_RFadrs      register being reserved
//  rsv_ready  out  1             reservation accepted (counter not saturated)
//  chk_src    in   t_RFadrs[`READ_PORTS]  source registers of instruction in issue
//  stall      out  1             any chk_src has pending count != 0
//  rf_dst     out  t_RFadrs      to RF write address (port 0)
//  rf_data    out  t_data        to RF write data
//  rf_wr_en   out  1             to RF write enable
// BEHAVIOUR
//  Reset (async, reset_n=0): all hold regs empty, all pending counters 0, rr pointer 0,
//   rf_wr_en=0, rf_dst=0, rf_data=0. req_ready=1, rsv_ready=1, stall=0 once reset is released.
//  Input handshake: transfer on req_valid[i]&&req_ready[i] at the edge; hold[i] loads dst/data.
//   req_ready[i] = !hold_v[i] || grant[i] (full-throughput when granted every cycle).
//  Arbitration (comb, each cycle): among hold_v[], pick the first at or after rr_ptr (mod N_REQ).
//   On a grant at edge: rr_ptr <= winner+1 (wraps N_REQ-1 -> 0), hold_v[winner] cleared
//   unless reloaded the same edge, rf_dst/rf_data <= hold[winner], rf_wr_en <= 1.
//   No grant: rf_wr_en <= 0, rf_dst/rf_data hold last value.
//  Latency: accepted at edge E0; rf_wr_en high during cycle after E1; RF written at E2.
//   Minimum 2 edges, accept to RF update; one write per cycle sustained.
//  Scoreboard: cnt[r] PEND_W bits per register, `REG_AMT entries.
//   +1 on rsv_valid&&rsv_ready for rsv_dst; -1 at edge where rf_wr_en=1 for rf_dst.
//   Both to same reg same edge: net 0. Decrement at 0: assertion error, counter stays 0.
//   rsv_ready = (cnt[rsv_dst] != max) || (rf_wr_en && rf_dst==rsv_dst).
//  stall (comb) = OR over chk_src of cnt[src]!=0. Counter clears only at the write edge.
//   So stall stays high during the rf_wr_en cycle: the RF read is comb and sees old data then.
//  Requesters must only write registers previously reserved (checked by assertion).
//  Reset mid-operation: held and in-flight writes are dropped and no RF write occurs;
//   rf_wr_en falls immediately (async).
// STRUCTURE
//  Shared package/defines: t_RFadrs, t_data, `REG_AMT, `READ_PORTS, `WRITE_PORTS; new typedef
//   t_wb_req {logic valid; t_RFadrs dst; t_data data;} added to the same package.
//  One sub-module: rr_arbiter (N param; req[N], ptr -> grant one-hot, winner index; comb).
//  Scoreboard counters and hold regs stay inline in rf_wb_arbiter.
// TESTING
//  1 Reset: assert reset_n=0 mid-stream with hold regs full -> rf_wr_en=0 at once, later stall=0.
//  2 Single ALU write: rsv r5, then req0 r5=0xA5 at E0 -> rf_wr_en=1,rf_dst=5 after E1.
//    stall(r5)=1 until E2, then 0.
//  3 Contention: req0 and req1 valid every cycle -> grants alternate 0,1,0,1, rf_wr_en stays 1.
//    req_ready toggles accordingly; no write lost or duplicated.
//  4 WAW/saturation (PEND_W=2): 3 reserves on r7 -> 4th rsv_ready=0.
//    Same cycle as a write to r7 -> rsv_ready=1, cnt stays 3.
//  5 Simultaneous reserve+retire of r3 with cnt=1 -> cnt remains 1, stall(r3)=1.
//  6 Back-pressure: req1 hold full and not granted for 3 cycles -> req_ready[1]=0.
//    req_data[1] changes are ignored until grant.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared register-file types and sizes for the writeback path
package rf_wb_arbiter_pkg;

   localparam int RF_ADRS_W   = 5;
   localparam int DATA_W      = 32;
   localparam int REG_AMT     = 32;
   localparam int READ_PORTS  = 2;
   localparam int WRITE_PORTS = 1;

   typedef logic [RF_ADRS_W-1:0] t_RFadrs;
   typedef logic [DATA_W-1:0]    t_data;

   typedef struct packed {
      logic    valid;
      t_RFadrs dst;
      t_data   data;
   } t_wb_req;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rtl/rf_wb_arbiter_rr.sv - combinational round-robin picker: first request at or after ptr
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] winner,
   output logic             any
);

   always_comb begin
      int idx;
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            winner     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the RF write port among writeback requesters
// and tracks pending writes per register to stall dependent issue.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int PEND_W = 2
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [N_REQ-1:0]                  req_valid,
   input  logic [N_REQ*RF_ADRS_W-1:0]        req_dst,
   input  logic [N_REQ*DATA_W-1:0]           req_data,
   output logic [N_REQ-1:0]                  req_ready,
   input  logic                              rsv_valid,
   input  logic [RF_ADRS_W-1:0]              rsv_dst,
   output logic                              rsv_ready,
   input  logic [READ_PORTS*RF_ADRS_W-1:0]   chk_src,
   output logic                              stall,
   output logic [RF_ADRS_W-1:0]              rf_dst,
   output logic [DATA_W-1:0]                 rf_data,
   output logic                              rf_wr_en
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

   t_wb_req          hold [N_REQ];
   logic [N_REQ-1:0] hold_v;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] winner;
   logic             any_grant;

   logic [PEND_W-1:0]  cnt [REG_AMT];
   logic [REG_AMT-1:0] inc_vec;
   logic [REG_AMT-1:0] dec_vec;
   logic               rsv_fire;

   always_comb begin
      hold_v = '0;
      for (int i = 0; i < N_REQ; i++) hold_v[i] = hold[i].valid;
   end

   rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req    (hold_v),
      .ptr    (rr_ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any_grant)
   );

   assign req_ready = ~hold_v | grant;
   assign rsv_ready = (cnt[rsv_dst] != CNT_MAX) || (rf_wr_en && (rf_dst == rsv_dst));
   assign rsv_fire  = rsv_valid && rsv_ready;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      stall   = 1'b0;
      if (rsv_fire) inc_vec[rsv_dst] = 1'b1;
      if (rf_wr_en) dec_vec[rf_dst]  = 1'b1;
      for (int p = 0; p < READ_PORTS; p++)
         if (cnt[chk_src[p*RF_ADRS_W +: RF_ADRS_W]] != '0) stall = 1'b1;
   end

   // A granted hold register may reload on the same edge it drains.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_REQ; i++) hold[i] <= '0;
         rr_ptr   <= '0;
         rf_wr_en <= 1'b0;
         rf_dst   <= '0;
         rf_data  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i])
               hold[i] <= '{valid: 1'b1,
                            dst:   req_dst[i*RF_ADRS_W +: RF_ADRS_W],
                            data:  req_data[i*DATA_W +: DATA_W]};
            else if (grant[i])
               hold[i].valid <= 1'b0;
         end
         rf_wr_en <= any_grant;
         if (any_grant) begin
            rf_dst  <= hold[winner].dst;
            rf_data <= hold[winner].data;
            rr_ptr  <= (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < REG_AMT; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < REG_AMT; r++) begin
            if (inc_vec[r] && !dec_vec[r])
               cnt[r] <= cnt[r] + 1'b1;
            else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         end
      end
   end

   always @(posedge clock) begin
      if (reset_n) begin
         if (rf_wr_en && !inc_vec[rf_dst])
            assert (cnt[rf_dst] != '0)
               else $error("rf_wb_arbiter: retire of r%0d with no pending write", rf_dst);
         for (int i = 0; i < N_REQ; i++)
            if (req_valid[i] && req_ready[i])
               assert (cnt[req_dst[i*RF_ADRS_W +: RF_ADRS_W]] != '0)
                  else $error("rf_wb_arbiter: requester %0d wrote unreserved register", i);
      end
   end

endmodule
